// File: rtl/cpu54_pkg.sv
// Shared definitions for the fetch stage: reset PC, redirect kind encodings, FSM states.
// FETCH_ALIGN_CHECK_EN adds the S_FAULT state used for misaligned jr targets.
package cpu54_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    typedef enum logic [1:0] {
        RK_BRANCH = 2'b00,
        RK_JUMP   = 2'b01,
        RK_JR     = 2'b10,
        RK_NONE   = 2'b11
    } redirect_kind_e;

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3
`ifdef FETCH_ALIGN_CHECK_EN
        , S_FAULT = 3'd4
`endif
    } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC logic: sequential pc+4 and the branch/jump/jr redirect target.
// With FETCH_ALIGN_CHECK_EN the raw target is passed through so the caller can fault on it.
module fetch_next_pc
    import cpu54_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  redirect_kind,
    input  logic [31:0] redirect_pc,
    input  logic [25:0] redirect_imm,
    input  logic [31:0] redirect_reg,
    output logic [31:0] seq_pc,
    output logic [31:0] target_pc,
    output logic        target_known
);

    logic [31:0] link_pc;
    logic [31:0] raw_target;

    always_comb begin
        seq_pc       = pc + 32'd4;
        link_pc      = redirect_pc + 32'd4;
        raw_target   = link_pc;
        target_known = 1'b1;
        case (redirect_kind)
            RK_BRANCH: raw_target = link_pc + {{14{redirect_imm[15]}}, redirect_imm[15:0], 2'b00};
            RK_JUMP:   raw_target = {link_pc[31:28], redirect_imm, 2'b00};
            RK_JR:     raw_target = redirect_reg;
            default:   target_known = 1'b0;
        endcase
`ifdef FETCH_ALIGN_CHECK_EN
        target_pc = raw_target;
`else
        target_pc = raw_target & ~32'h3;
`endif
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, single-outstanding imem reads, valid/ready hand-off to decode.
// Optional FETCH_ALIGN_CHECK_EN: misaligned jr target traps into a sticky fault state.
module instruction_fetch_unit
    import cpu54_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_kind,
    input  logic [31:0] redirect_pc,
    input  logic [25:0] redirect_imm,
    input  logic [31:0] redirect_reg,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic        ifu_fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic         if_valid_q, if_valid_d;
    logic         kill_q, kill_d;

    logic [31:0]  seq_pc, target_pc;
    logic         target_known, in_fault, take;

    fetch_next_pc u_next_pc (
        .pc            (pc_q),
        .redirect_kind (redirect_kind),
        .redirect_pc   (redirect_pc),
        .redirect_imm  (redirect_imm),
        .redirect_reg  (redirect_reg),
        .seq_pc        (seq_pc),
        .target_pc     (target_pc),
        .target_known  (target_known)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    assign in_fault = (state_q == S_FAULT);
`else
    assign in_fault = 1'b0;
`endif

    // Kind 11 and redirects during the post-reset idle cycle or a fault are no-ops.
    assign take = redirect_valid && target_known && (state_q != S_START) && !in_fault;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        kill_d     = kill_q;
        imem_req   = 1'b0;
        case (state_q)
            S_START: state_d = S_ISSUE;
            S_ISSUE: begin
                imem_req = !take;
                if (!take) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid && !take) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_ISSUE;
                    end else begin
                        if_instr_d = imem_rdata;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        state_d    = S_HOLD;
                    end
                end else if (imem_rvalid) begin
                    state_d = S_ISSUE;
                end else if (take) begin
                    // response still in flight for the old PC; drop it when it lands
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (take) begin
                    state_d = S_ISSUE;
                end else if (if_ready) begin
                    pc_d       = seq_pc;
                    if_valid_d = 1'b0;
                    state_d    = S_ISSUE;
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            S_FAULT: state_d = S_FAULT;
`endif
            default: state_d = S_START;
        endcase

        if (take) begin
            pc_d       = target_pc;
            if_valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (redirect_kind == RK_JR && target_pc[1:0] != 2'b00) state_d = S_FAULT;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_START;
            pc_q       <= RESET_PC;
            if_instr_q <= 32'd0;
            if_pc_q    <= 32'd0;
            if_valid_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
            kill_q     <= kill_d;
        end
    end

    assign imem_addr = pc_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign if_valid  = if_valid_q;
    assign ifu_fault = in_fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: flag-level reference model checked every cycle,
// a latency-programmable instruction memory, and directed redirect/reset scenarios.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [1:0]  redirect_kind;
    logic [31:0] redirect_pc;
    logic [25:0] redirect_imm;
    logic [31:0] redirect_reg;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        if_ready;
    logic        ifu_fault;

    int n_chk = 0;
    int n_fail = 0;
    int mem_lat = 1;
    logic [31:0] req_log[$];
    logic [31:0] acc_pc[$];
    logic [31:0] acc_ins[$];

    instruction_fetch_unit dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_kind(redirect_kind),
        .redirect_pc(redirect_pc), .redirect_imm(redirect_imm), .redirect_reg(redirect_reg),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid), .if_ready(if_ready),
        .ifu_fault(ifu_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a;
    endfunction

    // Memory: sees requests on the falling edge, answers mem_lat cycles later.
    initial begin
        logic        got;
        logic [31:0] a, slot_a;
        int          cnt;
        cnt = 0;
        slot_a = 0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        forever begin
            @(negedge clk);
            got = (imem_req === 1'b1);
            a   = imem_addr;
            if (got) begin
                req_log.push_back(a);
                chk("one_outstanding", 32'(cnt > 0), 32'd0);
            end
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (got) begin
                cnt    = mem_lat;
                slot_a = a;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(slot_a);
                end
            end
        end
    end

    // Reference model: tracks outstanding/stale/held flags and the PC the spec implies.
    bit          m_known = 0, m_started, m_out, m_stale, m_valid, m_fault;
    logic [31:0] m_pc, m_instr, m_ipc;

    function automatic logic [31:0] model_target(input logic [1:0] k, input logic [31:0] rpc,
                                                 input logic [25:0] imm, input logic [31:0] rr);
        int off;
        off = int'($signed(imm[15:0]));
        case (k)
            2'b00:   return rpc + 32'd4 + 32'(off * 4);
            2'b01:   return ((rpc + 32'd4) & 32'hF000_0000) | (32'(imm) * 32'd4);
            default: return rr & ~32'h3;
        endcase
    endfunction

    always @(negedge clk) begin : model_cmp
        bit          redir, issue_ok, o_out, o_stale, o_valid;
        logic [31:0] o_pc;
        issue_ok = m_started && !m_out && !m_valid && !m_fault;
        redir    = m_started && !m_fault && redirect_valid && (redirect_kind != 2'b11);
        if (m_known) begin
            chk("imem_req", 32'(imem_req), 32'(issue_ok && !redir));
            if (issue_ok && !redir) chk("imem_addr", imem_addr, m_pc);
            chk("if_valid", 32'(if_valid), 32'(m_valid));
            chk("if_pc", if_pc, m_ipc);
            chk("if_instr", if_instr, m_instr);
            chk("ifu_fault", 32'(ifu_fault), 32'(m_fault));
            if (if_valid === 1'b1 && if_ready && !redir && !rst) begin
                acc_pc.push_back(if_pc);
                acc_ins.push_back(if_instr);
            end
        end
        o_out = m_out; o_stale = m_stale; o_valid = m_valid; o_pc = m_pc;
        if (rst) begin
            m_known = 1; m_started = 0; m_out = 0; m_stale = 0; m_valid = 0; m_fault = 0;
            m_pc = 32'h0040_0000; m_instr = 0; m_ipc = 0;
        end else if (!m_started) begin
            m_started = 1;
        end else if (!m_fault) begin
            if (o_out && imem_rvalid) begin
                m_out = 0;
                if (!redir) begin
                    if (o_stale) m_stale = 0;
                    else begin
                        m_valid = 1; m_instr = imem_rdata; m_ipc = o_pc;
                    end
                end
            end else if (o_out && redir) begin
                m_stale = 1;
            end
            if (issue_ok && !redir) m_out = 1;
            if (o_valid && if_ready && !redir) begin
                m_valid = 0;
                m_pc = o_pc + 32'd4;
            end
            if (redir) begin
                m_valid = 0;
                m_pc = model_target(redirect_kind, redirect_pc, redirect_imm, redirect_reg);
`ifdef FETCH_ALIGN_CHECK_EN
                if (redirect_kind == 2'b10 && redirect_reg[1:0] != 2'b00) m_fault = 1;
`endif
            end
        end
    end

    task automatic wait_reqs(input int n, input string nm);
        bit ok = 0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk); #1;
            ok = (req_log.size() >= n);
        end
        chk({"wait_", nm}, 32'(ok), 32'd1);
    endtask

    task automatic wait_acc(input int n, input string nm);
        bit ok = 0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk); #1;
            ok = (acc_pc.size() >= n);
        end
        chk({"wait_", nm}, 32'(ok), 32'd1);
    endtask

    task automatic wait_valid(input string nm);
        bit ok = 0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk); #1;
            ok = (if_valid === 1'b1);
        end
        chk({"wait_", nm}, 32'(ok), 32'd1);
    endtask

    task automatic redirect(input logic [1:0] k, input logic [31:0] rpc, input logic [25:0] imm,
                            input logic [31:0] rr, input logic rdy);
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_kind = k; redirect_pc = rpc;
        redirect_imm = imm; redirect_reg = rr; if_ready = rdy;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    initial begin
        int n, m;
        logic [31:0] p;
        rst = 1'b1; redirect_valid = 1'b0; redirect_kind = 2'b00; redirect_pc = 0;
        redirect_imm = 0; redirect_reg = 0; if_ready = 1'b1;

        // 1: reset values, then sequential fetch from RESET_PC with latency 1
        @(negedge clk); @(negedge clk);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_fault", 32'(ifu_fault), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        wait_acc(3, "seq3");
        chk("t1_addr0", req_log[0], 32'h0040_0000);
        chk("t1_addr1", req_log[1], 32'h0040_0004);
        chk("t1_addr2", req_log[2], 32'h0040_0008);
        chk("t1_pc0", acc_pc[0], 32'h0040_0000);
        chk("t1_pc2", acc_pc[2], 32'h0040_0008);
        chk("t1_ins1", acc_ins[1], 32'hFFBF_FFFB);

        // 2: decode stalls for 5 cycles
        @(posedge clk); #1 if_ready = 1'b0;
        wait_valid("hold");
        n = req_log.size(); p = if_pc;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("t2_pc_stable", if_pc, p);
            chk("t2_instr_stable", if_instr, ~p);
        end
        chk("t2_no_req", 32'(req_log.size()), 32'(n));
        @(posedge clk); #1 if_ready = 1'b1;
        wait_reqs(n + 1, "t2_next");
        chk("t2_next_addr", req_log[n], p + 32'd4);

        // 3: branch back (-2) while held, then forward (+3) with if_ready in the same cycle
        @(posedge clk); #1 if_ready = 1'b0;
        wait_valid("t3a");
        n = req_log.size();
        redirect(2'b00, 32'h0040_0010, 26'h000FFFE, 32'd0, 1'b0);
        wait_reqs(n + 1, "t3a_req");
        chk("t3_back_addr", req_log[n], 32'h0040_000C);
        wait_valid("t3b");
        chk("t3_back_pc", if_pc, 32'h0040_000C);
        n = req_log.size(); m = acc_pc.size();
        redirect(2'b00, 32'h0040_0010, 26'h0000003, 32'd0, 1'b1);
        wait_reqs(n + 1, "t3b_req");
        chk("t3_fwd_addr", req_log[n], 32'h0040_0020);
        wait_acc(m + 1, "t3_acc");
        chk("t3_fwd_pc", acc_pc[m], 32'h0040_0020);

        // 4: jump during a slow (latency 4) read; stale data must be dropped
        mem_lat = 4;
        n = req_log.size();
        wait_reqs(n + 1, "t4_req");
        m = acc_pc.size();
        redirect(2'b01, 32'h0040_0010, 26'h0100040, 32'd0, 1'b1);
        wait_reqs(n + 2, "t4_req2");
        chk("t4_jump_addr", req_log[n + 1], 32'h0040_0100);
        wait_acc(m + 1, "t4_acc");
        chk("t4_jump_pc", acc_pc[m], 32'h0040_0100);
        chk("t4_jump_ins", acc_ins[m], 32'hFFBF_FEFF);

        // 5: jr to a misaligned register value
        mem_lat = 1;
        @(posedge clk); #1 if_ready = 1'b0;
        wait_valid("t5");
        n = req_log.size();
        redirect(2'b10, 32'h0040_0010, 26'd0, 32'h0040_0102, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
        repeat (10) @(negedge clk);
        #1;
        chk("t5_fault", 32'(ifu_fault), 32'd1);
        chk("t5_no_req", 32'(req_log.size()), 32'(n));
        chk("t5_if_valid", 32'(if_valid), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
`else
        wait_reqs(n + 1, "t5_req");
        chk("t5_jr_addr", req_log[n], 32'h0040_0100);
`endif
        @(posedge clk); #1 if_ready = 1'b1;

        // 6: reset while a read is outstanding; the late response must be ignored
        mem_lat = 2;
        n = req_log.size();
        wait_reqs(n + 1, "t6_req");
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); #1;
        chk("t6_valid_low", 32'(if_valid), 32'd0);
        m = acc_pc.size();
        wait_reqs(n + 2, "t6_refetch");
        chk("t6_refetch_addr", req_log[n + 1], 32'h0040_0000);
        wait_acc(m + 1, "t6_acc");
        chk("t6_refetch_pc", acc_pc[m], 32'h0040_0000);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
